// File: rtl/button_step_ctrl.sv
// button_step_ctrl: synchronised, debounced up/down buttons -> one-cycle step pulse plus direction level.
// Define AUTO_REPEAT_EN to build the hold-to-repeat state and its timer.
module button_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up,
   input  logic btn_down,
   output logic enable,
   output logic forward,
   output logic held
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;
   state_t state_q;
   logic [1:0] sync1_q, sync2_q, db_q;
   logic [DW-1:0] cnt_q [2];
   logic u, d, act, other;
   assign u = db_q[1];
   assign d = db_q[0];
   assign act = forward ? u : d;
   assign other = forward ? d : u;
`ifdef AUTO_REPEAT_EN
   localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW = $clog2(RMAX) + 1;
   localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);
   logic [TW-1:0] tmr_q;
`else
   logic unused_rpt;
   assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE};
`endif
   // Counter restarts on any sample matching the current level, so only an unbroken run flips it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
      end else begin
         sync1_q <= {btn_up, btn_down};
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) cnt_q[i] <= '0;
            else if (cnt_q[i] == DB_LAST) begin
               cnt_q[i] <= '0;
               db_q[i] <= sync2_q[i];
            end else cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end
   // Timer defaults to zero so every state entry starts it afresh.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         enable <= 1'b0;
         forward <= 1'b1;
         held <= 1'b0;
`ifdef AUTO_REPEAT_EN
         tmr_q <= '0;
`endif
      end else begin
         enable <= 1'b0;
`ifdef AUTO_REPEAT_EN
         tmr_q <= '0;
`endif
         case (state_q)
            IDLE:
               if (u && d) state_q <= LOCK;
               else if (u || d) begin
                  state_q <= HOLD;
                  enable <= 1'b1;
                  forward <= u;
                  held <= 1'b1;
               end
            HOLD:
               if (!act) begin
                  state_q <= IDLE;
                  held <= 1'b0;
               end else if (other) begin
                  state_q <= LOCK;
                  held <= 1'b0;
               end
`ifdef AUTO_REPEAT_EN
               else if (tmr_q == DELAY_LAST) begin
                  state_q <= REPEAT;
                  enable <= 1'b1;
               end else tmr_q <= tmr_q + 1'b1;
            REPEAT:
               if (!act) begin
                  state_q <= IDLE;
                  held <= 1'b0;
               end else if (other) begin
                  state_q <= LOCK;
                  held <= 1'b0;
               end else if (tmr_q == RATE_LAST) enable <= 1'b1;
               else tmr_q <= tmr_q + 1'b1;
`endif
            LOCK:
               if (!u && !d) state_q <= IDLE;
            default: begin
               state_q <= IDLE;
               held <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_button_step_ctrl.sv
// tb_button_step_ctrl: vector table, corner sequences and random stimulus against a windowed reference model.
module tb_button_step_ctrl;
   localparam int DEB = 4, RD = 20, RR = 8;
`ifdef AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
   logic enable, forward, held;
   int checks = 0, errors = 0;
   int pulses = 0, tcnt = 0;
   int ptimes[$];
   int exp_t[$];
   bit m_s1[2], m_s2[2], m_db[2];
   logic [DEB-1:0] m_win[2];
   int m_mode, m_start, m_n;
   bit m_en, m_fwd, m_held;

   typedef struct {bit up; bit dn; int len; int pulses; bit fwd; bit held;} vec_t;
   vec_t vecs[8];

   button_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
      .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
      .enable(enable), .forward(forward), .held(held));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void model_reset();
      m_s1 = '{0, 0}; m_s2 = '{0, 0}; m_db = '{0, 0};
      m_win[0] = '0; m_win[1] = '0;
      m_mode = 0; m_start = 0; m_n = 0;
      m_en = 1'b0; m_fwd = 1'b1; m_held = 1'b0;
   endfunction

   // Index 0 = up, 1 = down. Debounced level flips once the last DEB synced samples all disagree with it.
   function automatic void model_step(input bit up, input bit dn);
      bit u, d, a, o;
      u = m_db[0];
      d = m_db[1];
      m_en = 1'b0;
      if (m_mode == 0) begin
         if (u && d) m_mode = 2;
         else if (u || d) begin
            m_mode = 1; m_start = m_n; m_en = 1'b1; m_fwd = u;
         end
      end else if (m_mode == 1) begin
         a = m_fwd ? u : d;
         o = m_fwd ? d : u;
         if (!a) m_mode = 0;
         else if (o) m_mode = 2;
         else if (AUTO && (m_n - m_start) >= RD && ((m_n - m_start - RD) % RR) == 0) m_en = 1'b1;
      end else if (!u && !d) m_mode = 0;
      m_held = (m_mode == 1);
      for (int i = 0; i < 2; i++) begin
         m_win[i] = {m_win[i][DEB-2:0], m_s2[i]};
         if (m_win[i] == {DEB{~m_db[i]}}) m_db[i] = ~m_db[i];
         m_s2[i] = m_s1[i];
      end
      m_s1[0] = up;
      m_s1[1] = dn;
      m_n++;
   endfunction

   task automatic cyc(input bit up, input bit dn);
      btn_up = up;
      btn_down = dn;
      @(posedge clk);
      if (reset) model_step(up, dn);
      #1;
      tcnt++;
      if (enable === 1'b1) begin
         pulses++;
         ptimes.push_back(tcnt);
      end
      check("model_enable", int'(enable), int'(m_en));
      check("model_forward", int'(forward), int'(m_fwd));
      check("model_held", int'(held), int'(m_held));
   endtask

   initial begin
      vecs = '{
         '{1, 0, 15, 1, 1, 1}, '{0, 0, 20, 0, 1, 0},
         '{0, 1, 15, 1, 0, 1}, '{0, 0, 20, 0, 0, 0},
         '{1, 1, 40, 0, 0, 0}, '{0, 0, 20, 0, 0, 0},
         '{1, 0, 12, 1, 1, 1}, '{0, 0, 20, 0, 1, 0}};
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_enable", int'(enable), 0);
      check("reset_forward", int'(forward), 1);
      check("reset_held", int'(held), 0);
      @(negedge clk) reset = 1'b1;
      for (int v = 0; v < 8; v++) begin
         pulses = 0;
         repeat (vecs[v].len) cyc(vecs[v].up, vecs[v].dn);
         check($sformatf("vec%0d_pulses", v), pulses, vecs[v].pulses);
         check($sformatf("vec%0d_forward", v), int'(forward), int'(vecs[v].fwd));
         check($sformatf("vec%0d_held", v), int'(held), int'(vecs[v].held));
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) cyc(1'b0, ((i / 2) % 2) == 0);
      check("bounce_pulses", pulses, 0);
      repeat (15) cyc(1'b0, 1'b1);
      check("bounce_settle_pulses", pulses, 1);
      check("bounce_forward", int'(forward), 0);
      repeat (20) cyc(1'b0, 1'b0);
      if (AUTO) exp_t = '{7, 27, 35, 43, 51, 59};
      else exp_t = '{7};
      ptimes.delete();
      tcnt = 0;
      repeat (60) cyc(1'b1, 1'b0);
      check("repeat_count", ptimes.size(), exp_t.size());
      for (int i = 0; i < exp_t.size() && i < ptimes.size(); i++)
         check($sformatf("repeat_time%0d", i), ptimes[i], exp_t[i]);
      repeat (20) cyc(1'b0, 1'b0);
      check("repeat_after_release", ptimes.size(), exp_t.size());
      repeat (14) cyc(1'b0, 1'b1);
      check("prereset_forward", int'(forward), 0);
      @(negedge clk) reset = 1'b0;
      model_reset();
      #1;
      check("async_rst_enable", int'(enable), 0);
      check("async_rst_forward", int'(forward), 1);
      check("async_rst_held", int'(held), 0);
      repeat (2) cyc(1'b0, 1'b1);
      @(negedge clk) reset = 1'b1;
      ptimes.delete();
      tcnt = 0;
      repeat (12) cyc(1'b0, 1'b1);
      check("post_reset_count", ptimes.size(), 1);
      if (ptimes.size() > 0) check("post_reset_time", ptimes[0], 7);
      check("post_reset_forward", int'(forward), 0);
      repeat (20) cyc(1'b0, 1'b0);
      for (int s = 0; s < 120; s++) begin
         bit ru, rdn;
         int len;
         ru = 1'($urandom_range(0, 1));
         rdn = 1'($urandom_range(0, 1));
         len = (s % 3 == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 40));
         repeat (len) cyc(ru, rdn);
      end
      repeat (20) cyc(1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
